mem_bank_rw: RTL and testbench

- Parametrised single-port register-bank memory with a valid/ready request handshake and byte-enable writes.
- A registered read response carries its own valid flag.
- Contents are cleared by a hardware init sequence after reset, one entry per cycle.
- Replaces fixed 8-entry/32-bit banks used as local scratch storage behind simple bus masters.

---
 rtl/mem_bank_rw_if.sv | 27 ++
 rtl/mem_bank_rw.sv | 153 +++++++++++++++
 tb/tb_mem_bank_rw.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_bank_rw_if.sv
// mem_bank_rw_if: request/response bus for the mem_bank_rw register bank.
// master = bus initiator, slave = memory bank.
interface mem_bank_rw_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic                    Req_Valid;
    logic                    Req_Ready;
    logic                    R_W;
    logic [ADDR_WIDTH-1:0]   Addr;
    logic [DATA_WIDTH-1:0]   Din;
    logic [DATA_WIDTH/8-1:0] Be;
    logic                    Rsp_Valid;
    logic [DATA_WIDTH-1:0]   Dout;
    logic                    Err;
    logic                    Init_Done;

    modport master (
        output Req_Valid, R_W, Addr, Din, Be,
        input  Req_Ready, Rsp_Valid, Dout, Err, Init_Done
    );

    modport slave (
        input  Req_Valid, R_W, Addr, Din, Be,
        output Req_Ready, Rsp_Valid, Dout, Err, Init_Done
    );
endinterface

// File: rtl/mem_bank_rw.sv
// mem_bank_rw: register-bank memory, valid/ready requests, byte-enable writes.
// MEM_BANK_BYPASS_EN: buffered array writes with read-after-write forwarding.
module mem_bank_rw #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    mem_bank_rw_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {S_INIT, S_IDLE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_init_done;
    logic                  r_rsp_valid;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_ready;
    logic                  w_init_we;
    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_rdata;

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_v;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    assign w_accept   = bus.Req_Valid && w_ready;
    assign w_in_range = (32'(bus.Addr) < DEPTH_U);
    assign w_wr       = w_accept && bus.R_W && w_in_range;
    assign w_old      = w_in_range ? r_mem[bus.Addr] : '0;

    // State register, init pointer and init-done flag
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= S_INIT;
            r_ptr       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_init_done <= (w_next == S_IDLE);
            if (w_init_we) r_ptr <= r_ptr + ADDR_WIDTH'(1);
        end
    end

    // Next state: sweep all entries in INIT, then accept requests in IDLE
    always_comb begin
        w_next    = r_state;
        w_ready   = 1'b0;
        w_init_we = 1'b0;
        unique case (r_state)
            S_INIT: begin
                w_init_we = 1'b1;
                if (r_ptr == LAST) w_next = S_IDLE;
            end
            S_IDLE: begin
                w_ready = 1'b1;
            end
        endcase
    end

`ifdef MEM_BANK_BYPASS_EN
    logic                  r_wb_valid;
    logic [ADDR_WIDTH-1:0] r_wb_addr;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic [NB-1:0]         r_wb_be;

    // Hold an accepted write for one cycle before it lands in the array
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_wb_be    <= '0;
        end else begin
            r_wb_valid <= w_wr;
            r_wb_addr  <= bus.Addr;
            r_wb_data  <= bus.Din;
            r_wb_be    <= bus.Be;
        end
    end

    assign w_rdata = (r_wb_valid && r_wb_addr == bus.Addr)
                   ? merge(w_old, r_wb_data, r_wb_be)
                   : w_old;

    // Array update: init clears, otherwise commit the buffered write
    always_ff @(posedge Clk) begin
        if (Reset) begin
            if (w_init_we) begin
                r_mem[r_ptr] <= '0;
            end else if (r_wb_valid) begin
                r_mem[r_wb_addr] <= merge(r_mem[r_wb_addr],
                                          r_wb_data, r_wb_be);
            end
        end
    end
`else
    assign w_rdata = w_old;

    // Array update: init clears, otherwise write accepted data at once
    always_ff @(posedge Clk) begin
        if (Reset) begin
            if (w_init_we) begin
                r_mem[r_ptr] <= '0;
            end else if (w_wr) begin
                r_mem[bus.Addr] <= merge(w_old, bus.Din, bus.Be);
            end
        end
    end
`endif

    // Registered response; write responses leave Dout alone
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_dout      <= '0;
        end else begin
            r_rsp_valid <= w_accept;
            r_err       <= w_accept && !w_in_range;
            if (w_accept && !bus.R_W) begin
                r_dout <= w_in_range ? w_rdata : '0;
            end
        end
    end

    assign bus.Req_Ready = w_ready;
    assign bus.Rsp_Valid = r_rsp_valid;
    assign bus.Dout      = r_dout;
    assign bus.Err       = r_err;
    assign bus.Init_Done = r_init_done;
endmodule

// File: tb/tb_mem_bank_rw.sv
// tb_mem_bank_rw: directed bench for mem_bank_rw (DEPTH=8 and DEPTH=6 banks).
// Works for both the default and MEM_BANK_BYPASS_EN builds.
module tb_mem_bank_rw;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    mem_bank_rw_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) b8 ();
    mem_bank_rw_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) b6 ();

    mem_bank_rw #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .DEPTH(8)) u8 (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (b8)
    );

    mem_bank_rw #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .DEPTH(6)) u6 (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (b6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic req8(input logic rw, input logic [2:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        b8.Req_Valid = 1'b1;
        b8.R_W       = rw;
        b8.Addr      = a;
        b8.Din       = d;
        b8.Be        = be;
        @(posedge clk); #1;
        b8.Req_Valid = 1'b0;
    endtask

    task automatic req6(input logic rw, input logic [2:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        b6.Req_Valid = 1'b1;
        b6.R_W       = rw;
        b6.Addr      = a;
        b6.Din       = d;
        b6.Be        = be;
        @(posedge clk); #1;
        b6.Req_Valid = 1'b0;
    endtask

    task automatic rd8(input string tag, input logic [2:0] a,
                       input logic [31:0] exp);
        req8(1'b0, a, 32'h0, 4'h0);
        check({tag, "_v"}, b8.Rsp_Valid, 1);
        check({tag, "_e"}, b8.Err, 0);
        check({tag, "_d"}, b8.Dout, exp);
    endtask

    task automatic wr8(input string tag, input logic [2:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] dout_exp);
        req8(1'b1, a, d, be);
        check({tag, "_v"}, b8.Rsp_Valid, 1);
        check({tag, "_e"}, b8.Err, 0);
        check({tag, "_d"}, b8.Dout, dout_exp);
    endtask

    task automatic rd6(input string tag, input logic [2:0] a,
                       input logic [31:0] exp, input logic err);
        req6(1'b0, a, 32'h0, 4'h0);
        check({tag, "_v"}, b6.Rsp_Valid, 1);
        check({tag, "_e"}, b6.Err, err);
        check({tag, "_d"}, b6.Dout, exp);
    endtask

    task automatic wr6(input string tag, input logic [2:0] a,
                       input logic [31:0] d, input logic err,
                       input logic [31:0] dout_exp);
        req6(1'b1, a, d, 4'hF);
        check({tag, "_v"}, b6.Rsp_Valid, 1);
        check({tag, "_e"}, b6.Err, err);
        check({tag, "_d"}, b6.Dout, dout_exp);
    endtask

    // Init window: Req_Ready low for 8 cycles while junk requests are held.
    task automatic init_window(input string tag);
        for (int i = 0; i < 8; i++) begin
            b8.Req_Valid = 1'b1;
            b8.R_W       = i[0];
            b8.Addr      = 3'd1;
            b8.Din       = 32'hFFFF_FFFF;
            b8.Be        = 4'hF;
            check({tag, "_rdy0"}, b8.Req_Ready, 0);
            check({tag, "_done0"}, b8.Init_Done, 0);
            @(posedge clk); #1;
            check({tag, "_norsp"}, b8.Rsp_Valid, 0);
        end
        b8.Req_Valid = 1'b0;
        check({tag, "_rdy1"}, b8.Req_Ready, 1);
        check({tag, "_done1"}, b8.Init_Done, 1);
    endtask

    function automatic logic [31:0] sdata(input int i);
        return 32'hA500_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        b8.Req_Valid = 1'b0; b8.R_W = 1'b0; b8.Addr = '0;
        b8.Din = '0; b8.Be = '0;
        b6.Req_Valid = 1'b0; b6.R_W = 1'b0; b6.Addr = '0;
        b6.Din = '0; b6.Be = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp", b8.Rsp_Valid, 0);
        check("rst_dout", b8.Dout, 0);
        check("rst_err", b8.Err, 0);
        check("rst_rdy", b8.Req_Ready, 0);
        rst_n = 1'b1;

        init_window("init");
        check("init6_done", b6.Init_Done, 1);
        for (int i = 0; i < 8; i++) rd8("init_rd", 3'(i), 32'h0);

        wr8("wr3", 3'd3, 32'hDEAD_BEEF, 4'hF, 32'h0);
        rd8("rd3", 3'd3, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check("idle_v", b8.Rsp_Valid, 0);
        check("idle_e", b8.Err, 0);
        check("idle_d", b8.Dout, 32'hDEAD_BEEF);

        wr8("be_full", 3'd5, 32'h1122_3344, 4'hF, 32'hDEAD_BEEF);
        wr8("be_0101", 3'd5, 32'hAABB_CCDD, 4'b0101, 32'hDEAD_BEEF);
        rd8("be_rd", 3'd5, 32'h11BB_33DD);
        wr8("be_none", 3'd5, 32'hFFFF_FFFF, 4'h0, 32'h11BB_33DD);
        rd8("be_rd2", 3'd5, 32'h11BB_33DD);
        wr8("be_1010", 3'd5, 32'h5566_7788, 4'b1010, 32'h11BB_33DD);
        rd8("be_rd3", 3'd5, 32'h55BB_77DD);

        wr6("oor_w0", 3'd0, 32'hCAFE_F00D, 1'b0, 32'h0);
        rd6("oor_r0", 3'd0, 32'hCAFE_F00D, 1'b0);
        wr6("oor_w7", 3'd7, 32'h1234_5678, 1'b1, 32'hCAFE_F00D);
        rd6("oor_r7", 3'd7, 32'h0, 1'b1);
        wr6("oor_w6", 3'd6, 32'h8765_4321, 1'b1, 32'h0);
        rd6("oor_r6", 3'd6, 32'h0, 1'b1);
        rd6("oor_k0", 3'd0, 32'hCAFE_F00D, 1'b0);
        for (int i = 1; i < 6; i++) rd6("oor_k", 3'(i), 32'h0, 1'b0);
        @(posedge clk); #1;
        check("oor_idle_v", b6.Rsp_Valid, 0);
        check("oor_idle_e", b6.Err, 0);

        for (int k = 0; k < 16; k++) begin
            b8.Req_Valid = 1'b1;
            b8.R_W       = (k % 2 == 0);
            b8.Addr      = 3'(k / 2);
            b8.Din       = sdata(k / 2);
            b8.Be        = 4'hF;
            @(posedge clk); #1;
            check("st_v", b8.Rsp_Valid, 1);
            check("st_e", b8.Err, 0);
            if (k % 2 == 1) check("st_d", b8.Dout, sdata(k / 2));
        end
        b8.Req_Valid = 1'b0;
        @(posedge clk); #1;
        check("st_idle", b8.Rsp_Valid, 0);
        rd8("st_re2", 3'd2, sdata(2));

        b8.Req_Valid = 1'b1;
        b8.R_W       = 1'b0;
        b8.Addr      = 3'd2;
        rst_n        = 1'b0;
        @(posedge clk); #1;
        b8.Req_Valid = 1'b0;
        check("mr_v", b8.Rsp_Valid, 0);
        check("mr_d", b8.Dout, 0);
        check("mr_rdy", b8.Req_Ready, 0);
        check("mr_done", b8.Init_Done, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        init_window("reinit");
        rd8("mr_r1", 3'd1, 32'h0);
        rd8("mr_r2", 3'd2, 32'h0);
        rd8("mr_r7", 3'd7, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
